axis_pkt_arbiter: RTL and testbench

- Merges NUM_SRC AXI-Stream packet sources, such as several packet generators, onto one shared AXI-Stream output.
- Arbitration is round-robin at packet granularity. Once a source is granted, it keeps the output until its tlast beat is accepted.
- Sits between the traffic sources and the downstream FIFO/sink. Data passes through with zero added latency while a grant is held.

---
 rtl/axis_pkt_arbiter.sv | 117 +++++++++++
 tb/tb_axis_pkt_arbiter.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_pkt_arbiter.sv
// axis_pkt_arbiter: packet-granular round-robin merge of NUM_SRC AXI-Stream sources onto one output.
// Optional build macro AXIS_ARB_SRC_ID_EN adds axis_out_tdest and per-source pkt_count.
module axis_pkt_arbiter #(
    parameter int unsigned DW      = 512,
    parameter int unsigned NUM_SRC = 4,
    localparam int unsigned SW     = $clog2(NUM_SRC),
    localparam int unsigned KW     = DW / 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic [NUM_SRC*DW-1:0]  axis_in_tdata,
    input  logic [NUM_SRC*KW-1:0]  axis_in_tkeep,
    input  logic [NUM_SRC-1:0]     axis_in_tlast,
    input  logic [NUM_SRC-1:0]     axis_in_tvalid,
    output logic [NUM_SRC-1:0]     axis_in_tready,
    output logic [DW-1:0]          axis_out_tdata,
    output logic [KW-1:0]          axis_out_tkeep,
    output logic                   axis_out_tlast,
    output logic                   axis_out_tvalid,
`ifdef AXIS_ARB_SRC_ID_EN
    output logic [SW-1:0]          axis_out_tdest,
    output logic [NUM_SRC*16-1:0]  pkt_count,
`endif
    input  logic                   axis_out_tready
);

    typedef enum logic {ARB, PASS} state_t;

    state_t        fsm_state;
    logic [SW-1:0] grant;
    logic [SW-1:0] last_grant;
    logic [SW-1:0] winner;
    logic          any_valid;
    logic          pass;
    logic          accept_last;

    // Round-robin pick: first valid index after last_grant, wrapping at NUM_SRC.
    always_comb begin : rr_pick
        logic [SW:0] idx;
        idx       = '0;
        winner    = last_grant;
        any_valid = 1'b0;
        for (int k = NUM_SRC; k >= 1; k--) begin
            idx = {1'b0, last_grant} + (SW+1)'(k);
            if (idx >= (SW+1)'(NUM_SRC)) begin
                idx = idx - (SW+1)'(NUM_SRC);
            end
            if (axis_in_tvalid[idx[SW-1:0]]) begin
                winner    = idx[SW-1:0];
                any_valid = 1'b1;
            end
        end
    end

    // Reset gates the datapath so outputs read zero while resetn is low.
    assign pass = (fsm_state == PASS) && resetn;

    always_comb begin : out_mux
        axis_out_tdata  = '0;
        axis_out_tkeep  = '0;
        axis_out_tlast  = 1'b0;
        axis_out_tvalid = 1'b0;
        axis_in_tready  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (pass && (grant == SW'(i))) begin
                axis_out_tdata    = axis_in_tdata[i*DW +: DW];
                axis_out_tkeep    = axis_in_tkeep[i*KW +: KW];
                axis_out_tlast    = axis_in_tlast[i];
                axis_out_tvalid   = axis_in_tvalid[i];
                axis_in_tready[i] = axis_out_tready;
            end
        end
    end

    assign accept_last = axis_out_tvalid & axis_out_tready & axis_out_tlast;

    always_ff @(posedge clk) begin : fsm
        if (!resetn) begin
            fsm_state  <= ARB;
            grant      <= '0;
            last_grant <= SW'(NUM_SRC - 1);
        end else begin
            case (fsm_state)
                ARB: begin
                    if (any_valid) begin
                        grant     <= winner;
                        fsm_state <= PASS;
                    end
                end
                PASS: begin
                    if (accept_last) begin
                        last_grant <= grant;
                        fsm_state  <= ARB;
                    end
                end
            endcase
        end
    end

`ifdef AXIS_ARB_SRC_ID_EN
    assign axis_out_tdest = pass ? grant : '0;

    // Per-source wrapping count of completed packets.
    always_ff @(posedge clk) begin : pkt_cnt
        if (!resetn) begin
            pkt_count <= '0;
        end else if (accept_last) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (grant == SW'(i)) begin
                    pkt_count[i*16 +: 16] <= pkt_count[i*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Bench for axis_pkt_arbiter: directed scenarios plus randomized traffic checked cycle by cycle
// against a packet-level round-robin model; AXIS_ARB_SRC_ID_EN also checks tdest and pkt_count.
module tb_axis_pkt_arbiter;

    localparam int unsigned DW = 32;
    localparam int unsigned N  = 4;
    localparam int unsigned SW = 2;
    localparam int unsigned KW = DW / 8;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    logic            clk = 1'b0;
    logic            resetn;
    logic [N*DW-1:0] in_tdata;
    logic [N*KW-1:0] in_tkeep;
    logic [N-1:0]    in_tlast;
    logic [N-1:0]    in_tvalid;
    logic [N-1:0]    in_tready;
    logic [DW-1:0]   out_tdata;
    logic [KW-1:0]   out_tkeep;
    logic            out_tlast;
    logic            out_tvalid;
    logic            out_tready;
`ifdef AXIS_ARB_SRC_ID_EN
    logic [SW-1:0]   out_tdest;
    logic [N*16-1:0] pkt_count;
`endif

    always #5 clk = ~clk;

    axis_pkt_arbiter #(.DW(DW), .NUM_SRC(N)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .axis_in_tdata  (in_tdata),
        .axis_in_tkeep  (in_tkeep),
        .axis_in_tlast  (in_tlast),
        .axis_in_tvalid (in_tvalid),
        .axis_in_tready (in_tready),
        .axis_out_tdata (out_tdata),
        .axis_out_tkeep (out_tkeep),
        .axis_out_tlast (out_tlast),
        .axis_out_tvalid(out_tvalid),
`ifdef AXIS_ARB_SRC_ID_EN
        .axis_out_tdest (out_tdest),
        .pkt_count      (pkt_count),
`endif
        .axis_out_tready(out_tready)
    );

    // Source queues and reference state: owner<0 means the arbiter is choosing.
    beat_t         q[N][$];
    logic [N-1:0]  en;
    logic [N-1:0]  vld;
    logic          rst_drv;
    logic          ordy;
    int            owner;
    int            last_g;
    int            cnt_model[N];
    int            pkt_id;
    int            tests;
    int            fails;
    logic [DW-1:0] obs[$];

    task automatic chk(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic add_pkt(input int src, input int len);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt.d = {8'(src), 8'(pkt_id), 8'(b), 8'($urandom)};
            bt.k = 4'($urandom_range(1, 15));
            bt.l = (b == len - 1);
            q[src].push_back(bt);
        end
        pkt_id++;
    endtask

    task automatic drive();
        for (int i = 0; i < int'(N); i++) begin
            if (q[i].size() > 0) begin
                in_tdata[i*DW +: DW] = q[i][0].d;
                in_tkeep[i*KW +: KW] = q[i][0].k;
                in_tlast[i]          = q[i][0].l;
                vld[i]               = en[i];
            end else begin
                in_tdata[i*DW +: DW] = '0;
                in_tkeep[i*KW +: KW] = '0;
                in_tlast[i]          = 1'b0;
                vld[i]               = 1'b0;
            end
        end
        in_tvalid  = vld;
        resetn     = rst_drv;
        out_tready = ordy;
    endtask

    // One clock: drive, check outputs at negedge, then advance the model at the edge.
    task automatic cycle();
        beat_t        hb;
        logic         ev;
        logic [N-1:0] er;
        int           nxt;
        drive();
        @(negedge clk);
        hb = '0;
        ev = 1'b0;
        er = '0;
        if (rst_drv && owner >= 0) begin
            ev = vld[owner];
            if (q[owner].size() > 0) hb = q[owner][0];
            er[owner] = ordy;
        end
        chk("out_tvalid", 32'(out_tvalid), 32'(ev));
        chk("out_tdata",  out_tdata,       hb.d);
        chk("out_tkeep",  32'(out_tkeep),  32'(hb.k));
        chk("out_tlast",  32'(out_tlast),  32'(hb.l));
        chk("in_tready",  32'(in_tready),  32'(er));
`ifdef AXIS_ARB_SRC_ID_EN
        chk("out_tdest",  32'(out_tdest),  (rst_drv && owner >= 0) ? 32'(owner) : 32'd0);
`endif
        if (out_tvalid === 1'b1 && ordy) obs.push_back(out_tdata);
        @(posedge clk);
        if (!rst_drv) begin
            owner  = -1;
            last_g = N - 1;
            for (int i = 0; i < int'(N); i++) cnt_model[i] = 0;
        end else if (owner < 0) begin
            nxt = -1;
            for (int k = 1; k <= int'(N); k++) begin
                if (nxt < 0 && vld[(last_g + k) % N]) nxt = (last_g + k) % N;
            end
            owner = nxt;
        end else if (vld[owner] && ordy) begin
            hb = q[owner].pop_front();
            if (hb.l) begin
                cnt_model[owner] = (cnt_model[owner] + 1) % 65536;
                last_g = owner;
                owner  = -1;
            end
        end
        #1;
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) cycle();
    endtask

    task automatic do_reset();
        rst_drv = 1'b0;
        cycle();
        rst_drv = 1'b1;
    endtask

    int exp_order[5] = '{0, 1, 2, 3, 0};

    initial begin
        tests   = 0;
        fails   = 0;
        pkt_id  = 0;
        owner   = -1;
        last_g  = N - 1;
        en      = '1;
        ordy    = 1'b1;
        rst_drv = 1'b0;
        for (int i = 0; i < int'(N); i++) cnt_model[i] = 0;

        // Reset state
        run(2);
        rst_drv = 1'b1;

        // Lone source 2, 3-beat packet
        obs.delete();
        add_pkt(2, 3);
        run(6);
        chk("t1_beats", 32'(obs.size()), 32'd3);
        for (int b = 0; b < obs.size() && b < 3; b++) begin
            chk("t1_src",  32'(obs[b][31:24]), 32'd2);
            chk("t1_beat", 32'(obs[b][15:8]),  32'(b));
        end

        // All sources busy: rotation 0,1,2,3,0
        do_reset();
        obs.delete();
        for (int p = 0; p < 5; p++) add_pkt(exp_order[p], 2);
        run(18);
        chk("t2_beats", 32'(obs.size()), 32'd10);
        for (int p = 0; p < 5 && 2*p+1 < obs.size(); p++)
            chk("t2_order", 32'(obs[2*p+1][31:24]), 32'(exp_order[p]));

        // Source 1 stalls mid-packet while source 0 waits
        obs.delete();
        add_pkt(1, 3);
        add_pkt(0, 2);
        run(2);
        en[1] = 1'b0;
        run(5);
        en[1] = 1'b1;
        run(10);
        chk("t3_beats", 32'(obs.size()), 32'd5);
        for (int b = 0; b < obs.size() && b < 5; b++)
            chk("t3_src", 32'(obs[b][31:24]), (b < 3) ? 32'd1 : 32'd0);

        // Toggling downstream ready
        obs.delete();
        add_pkt(0, 4);
        for (int c = 0; c < 12; c++) begin
            ordy = (c % 2 == 0);
            cycle();
        end
        ordy = 1'b1;
        chk("t4_beats", 32'(obs.size()), 32'd4);
        for (int b = 0; b < obs.size() && b < 4; b++)
            chk("t4_order", 32'(obs[b][15:8]), 32'(b));

        // Reset lands on beat 2 of a source-3 packet
        add_pkt(3, 4);
        run(2);
        rst_drv = 1'b0;
        cycle();
        rst_drv = 1'b1;
        q[3].delete();
        obs.delete();
        add_pkt(0, 2);
        add_pkt(3, 2);
        run(10);
        chk("t5_beats", 32'(obs.size()), 32'd4);
        if (obs.size() >= 4) begin
            chk("t5_first",  32'(obs[1][31:24]), 32'd0);
            chk("t5_second", 32'(obs[3][31:24]), 32'd3);
        end

`ifdef AXIS_ARB_SRC_ID_EN
        // Packet counters: three from source 1, one from source 2
        do_reset();
        for (int p = 0; p < 3; p++) add_pkt(1, 2);
        add_pkt(2, 3);
        run(20);
        chk("cnt_src1", 32'(pkt_count[16 +: 16]), 32'd3);
        chk("cnt_src2", 32'(pkt_count[32 +: 16]), 32'd1);
`endif

        // Randomized traffic with stalls, backpressure and one mid-run reset
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < int'(N); i++)
                if (q[i].size() < 6 && $urandom_range(0, 3) == 0) add_pkt(i, $urandom_range(1, 5));
            en   = N'($urandom);
            ordy = ($urandom_range(0, 3) != 0);
            if (c == 250) begin
                do_reset();
                for (int i = 0; i < int'(N); i++) q[i].delete();
            end else begin
                cycle();
            end
        end
        en   = '1;
        ordy = 1'b1;
        run(150);
        for (int i = 0; i < int'(N); i++) chk("drained", 32'(q[i].size()), 32'd0);
`ifdef AXIS_ARB_SRC_ID_EN
        for (int i = 0; i < int'(N); i++) chk("cnt_rand", 32'(pkt_count[i*16 +: 16]), 32'(cnt_model[i]));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
